// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and byte-lane helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ      = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_DONE     = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] WSTRB_B = 4'b0001;
  localparam logic [3:0] WSTRB_H = 4'b0011;
  localparam logic [3:0] WSTRB_W = 4'b1111;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    if (f3 == F3_H || f3 == F3_HU) mis = off[0];
    else if (f3 == F3_W)           mis = (off != 2'b00);
    return mis;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] strb;
    case (f3)
      F3_B:    strb = WSTRB_B << off;
      F3_H:    strb = WSTRB_H << off;
      default: strb = WSTRB_W;
    endcase
    return strb;
  endfunction

  // Replicate the store operand across every lane so the strobes pick the byte.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (f3)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] mem_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    mem_out = rdata;
    case (funct3)
      F3_B:    mem_out = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   mem_out = {24'h0, byte_sel};
      F3_H:    mem_out = {{16{half_sel[15]}}, half_sel};
      F3_HU:   mem_out = {16'h0, half_sel};
      default: mem_out = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage engine: one valid/ready data-memory transaction per load/store,
// with alignment/legality checks, response timeout and load extension.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] mem_out,
  output logic        misalign_err,
  output logic        access_err,
  output logic        bus_err,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

  lsu_state_t  state, state_next;
  logic        op_store;
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic [7:0]  cnt;
  logic [7:0]  cnt_inc;
  logic        req_legal;
  logic        req_mis;
  logic [31:0] ext_data;

  load_extend u_load_extend (
    .rdata   (dmem_rdata),
    .off     (op_off),
    .funct3  (op_f3),
    .mem_out (ext_data)
  );

  assign cnt_inc = cnt + 8'd1;

  always_comb begin
    req_legal  = f3_legal(req_is_store, req_funct3);
    req_mis    = f3_misaligned(req_funct3, req_addr[1:0]);
    state_next = state;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid && req_legal && !req_mis) begin
          state_next = S_REQ;
          stall      = 1'b1;
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (dmem_req_ready) state_next = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        stall = 1'b1;
        if (dmem_rsp_valid || cnt_inc == TIMEOUT_VAL) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      done           <= 1'b0;
      mem_out        <= 32'h0;
      misalign_err   <= 1'b0;
      access_err     <= 1'b0;
      bus_err        <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'h0;
      dmem_wdata     <= 32'h0;
      dmem_wstrb     <= 4'h0;
      cnt            <= 8'h0;
      op_store       <= 1'b0;
      op_f3          <= 3'b000;
      op_off         <= 2'b00;
    end else begin
      state        <= state_next;
      done         <= 1'b0;
      misalign_err <= 1'b0;
      access_err   <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (!req_legal) begin
              access_err <= 1'b1;
            end else if (req_mis) begin
              misalign_err <= 1'b1;
            end else begin
              op_store       <= req_is_store;
              op_f3          <= req_funct3;
              op_off         <= req_addr[1:0];
              dmem_req_valid <= 1'b1;
              dmem_we        <= req_is_store;
              dmem_addr      <= {req_addr[31:2], 2'b00};
              dmem_wstrb     <= req_is_store ? store_strb(req_funct3, req_addr[1:0]) : 4'h0;
              dmem_wdata     <= req_is_store ? store_lanes(req_funct3, req_wdata) : 32'h0;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            cnt            <= 8'h0;
          end
        end
        S_WAIT_RSP: begin
          cnt <= cnt_inc;
          // A response in the final counted cycle still wins over the timeout.
          if (dmem_rsp_valid) begin
            done    <= 1'b1;
            mem_out <= op_store ? 32'h0 : ext_data;
          end else if (cnt_inc == TIMEOUT_VAL) begin
            done    <= 1'b1;
            bus_err <= 1'b1;
            mem_out <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
